// File: rtl/pipe_collision_scorer_if.sv
// Bundle of pipe/bird geometry and game state in, score and hit events out.
// The game datapath drives the master side; the scorer sits on the slave side.
interface pipe_collision_scorer_if;
  logic        [1:0]  iState;
  logic signed [16:0] iPipe1X;
  logic signed [16:0] iPipe2X;
  logic signed [16:0] iPipe3X;
  logic signed [16:0] iPipe1Y;
  logic signed [16:0] iPipe2Y;
  logic signed [16:0] iPipe3Y;
  logic signed [16:0] iBirdY;
  logic        [11:0] oScore;
  logic        [11:0] oHighScore;
  logic               oScorePulse;
  logic               oCollision;
  logic               oHit;

  modport master (
    output iState, iPipe1X, iPipe2X, iPipe3X, iPipe1Y, iPipe2Y, iPipe3Y, iBirdY,
    input  oScore, oHighScore, oScorePulse, oCollision, oHit
  );

  modport slave (
    input  iState, iPipe1X, iPipe2X, iPipe3X, iPipe1Y, iPipe2Y, iPipe3Y, iBirdY,
    output oScore, oHighScore, oScorePulse, oCollision, oHit
  );
endinterface

// File: rtl/pipe_collision_scorer.sv
// Round-robin pipe scanner: detects bird/pipe and boundary hits, counts passed
// pipes into a saturating 3-digit BCD score and tracks a persistent high score.
module pipe_collision_scorer #(
  parameter int SCREEN_WIDTH    = 640,
  parameter int SCREEN_HEIGHT   = 480,
  parameter int PIPE_WIDTH      = 52,
  parameter int PIPE_GAP_HEIGHT = 100,
  parameter int BIRD_X          = 160,
  parameter int BIRD_SIZE       = 24
) (
  input  logic                    iClock,
  input  logic                    iReset,
  pipe_collision_scorer_if.slave  bus
);

  localparam logic signed [16:0] ScreenW  = 17'(SCREEN_WIDTH);
  localparam logic signed [16:0] ScreenH  = 17'(SCREEN_HEIGHT);
  localparam logic signed [16:0] PipeW    = 17'(PIPE_WIDTH);
  localparam logic signed [16:0] GapH     = 17'(PIPE_GAP_HEIGHT);
  localparam logic signed [16:0] BirdX    = 17'(BIRD_X);
  localparam logic signed [16:0] BirdSize = 17'(BIRD_SIZE);
  localparam logic signed [16:0] Invalid  = -17'sd1;

  typedef enum logic [1:0] {SCAN1, SCAN2, SCAN3} scanState_t;

  scanState_t  state_q, state_d;
  logic [2:0]  passed_q, passed_d;
  logic [11:0] score_q, score_d;
  logic [11:0] high_q, high_d;
  logic        pulse_q, pulse_d;
  logic        coll_q, coll_d;
  logic        hit_q, hit_d;

  logic signed [16:0] selX, selY;
  logic [1:0]         selIdx;
  logic               pipeValid, respawn, passEvt, overlapX, missGap, pipeHit, boundHit;

  // Saturating BCD increment; 999 stays at 999.
  function automatic logic [11:0] bcdInc(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v != 12'h999) begin
      if (v[3:0] == 4'd9) begin
        r[3:0] = 4'd0;
        if (v[7:4] == 4'd9) begin
          r[7:4]  = 4'd0;
          r[11:8] = v[11:8] + 4'd1;
        end else begin
          r[7:4] = v[7:4] + 4'd1;
        end
      end else begin
        r[3:0] = v[3:0] + 4'd1;
      end
    end
    return r;
  endfunction

  always_comb begin
    selX   = bus.iPipe1X;
    selY   = bus.iPipe1Y;
    selIdx = 2'd0;
    case (state_q)
      SCAN2: begin selX = bus.iPipe2X; selY = bus.iPipe2Y; selIdx = 2'd1; end
      SCAN3: begin selX = bus.iPipe3X; selY = bus.iPipe3Y; selIdx = 2'd2; end
      default: ;
    endcase
  end

  assign pipeValid = (selY != Invalid);
  assign respawn   = (selX >= ScreenW);
  assign passEvt   = pipeValid && (selX + PipeW < BirdX) && !passed_q[selIdx];
  assign overlapX  = (selX < BirdX + BirdSize) && (selX + PipeW > BirdX);
  assign missGap   = (bus.iBirdY < selY) || (bus.iBirdY + BirdSize > selY + GapH);
  assign pipeHit   = pipeValid && overlapX && missGap;
  assign boundHit  = (bus.iBirdY < 17'sd0) || (bus.iBirdY + BirdSize > ScreenH);

  // Scanning and scoring only run while playing and not yet hit.
  always_comb begin
    state_d  = state_q;
    passed_d = passed_q;
    score_d  = score_q;
    high_d   = (score_q > high_q) ? score_q : high_q;
    pulse_d  = 1'b0;
    coll_d   = 1'b0;
    hit_d    = hit_q;
    if (bus.iState != 2'd1) begin
      state_d  = SCAN1;
      passed_d = 3'b000;
      hit_d    = 1'b0;
      if (bus.iState == 2'd0) score_d = 12'h000;
    end else if (hit_q) begin
      state_d = SCAN1;
    end else begin
      case (state_q)
        SCAN1:   state_d = SCAN2;
        SCAN2:   state_d = SCAN3;
        default: state_d = SCAN1;
      endcase
      if (respawn) passed_d[selIdx] = 1'b0;
      if (passEvt) begin
        passed_d[selIdx] = 1'b1;
        score_d          = bcdInc(score_q);
        pulse_d          = 1'b1;
      end
      if (pipeHit || boundHit) begin
        hit_d  = 1'b1;
        coll_d = 1'b1;
      end
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q  <= SCAN1;
      passed_q <= 3'b000;
      score_q  <= 12'h000;
      high_q   <= 12'h000;
      pulse_q  <= 1'b0;
      coll_q   <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      passed_q <= passed_d;
      score_q  <= score_d;
      high_q   <= high_d;
      pulse_q  <= pulse_d;
      coll_q   <= coll_d;
      hit_q    <= hit_d;
    end
  end

  assign bus.oScore      = score_q;
  assign bus.oHighScore  = high_q;
  assign bus.oScorePulse = pulse_q;
  assign bus.oCollision  = coll_q;
  assign bus.oHit        = hit_q;

endmodule

// File: tb/tb_pipe_collision_scorer.sv
// Directed bench for pipe_collision_scorer: scoring, collisions, boundaries,
// BCD carry/saturation and high-score persistence.
module tb_pipe_collision_scorer;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   pulseCount = 0;
  int   collCount = 0;
  int   pulseBase;
  int   collBase;

  pipe_collision_scorer_if ifc();

  pipe_collision_scorer dut (
    .iClock (clock),
    .iReset (reset),
    .bus    (ifc.slave)
  );

  always #5 clock = ~clock;

  // Each edge sees the pulse that was held during the previous cycle.
  always @(posedge clock) begin
    if (ifc.oScorePulse) pulseCount++;
    if (ifc.oCollision)  collCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic applyStimulus(input logic [1:0] st, input int birdY);
    ifc.iState = st;
    ifc.iBirdY = 17'(birdY);
  endtask

  task automatic setPipe(input int idx, input int x, input int y);
    case (idx)
      1: begin ifc.iPipe1X = 17'(x); ifc.iPipe1Y = 17'(y); end
      2: begin ifc.iPipe2X = 17'(x); ifc.iPipe2Y = 17'(y); end
      default: begin ifc.iPipe3X = 17'(x); ifc.iPipe3Y = 17'(y); end
    endcase
  endtask

  // One full pass of pipe 1: behind the bird, then respawned.
  task automatic doPass();
    setPipe(1, 107, 150);
    waitCycles(4);
    setPipe(1, 640, 150);
    waitCycles(4);
  endtask

  task automatic sweepPipe1();
    for (int x = 640; x >= 108; x--) begin
      ifc.iPipe1X = 17'(x);
      waitCycles(1);
    end
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(2'd1, 200);
    setPipe(1, 640, 150);
    setPipe(2, 640, 150);
    setPipe(3, 640, 150);
    waitCycles(2);
    checkOutput("rst_score", 32'(ifc.oScore), 32'h000);
    checkOutput("rst_high", 32'(ifc.oHighScore), 32'h000);
    checkOutput("rst_hit", 32'(ifc.oHit), 32'd0);
    checkOutput("rst_pulse", 32'(ifc.oScorePulse), 32'd0);
    checkOutput("rst_coll", 32'(ifc.oCollision), 32'd0);

    // Idle playfield for 1000 cycles
    reset = 1'b0;
    pulseBase = pulseCount;
    collBase  = collCount;
    waitCycles(1000);
    checkOutput("idle_score", 32'(ifc.oScore), 32'h000);
    checkOutput("idle_hit", 32'(ifc.oHit), 32'd0);
    checkOutput("idle_pulses", 32'(pulseCount - pulseBase), 32'd0);
    checkOutput("idle_colls", 32'(collCount - collBase), 32'd0);

    // Sweep pipe 1 past the bird twice
    applyStimulus(2'd1, 170);
    pulseBase = pulseCount;
    sweepPipe1();
    waitCycles(5);
    checkOutput("x108_score", 32'(ifc.oScore), 32'h000);
    ifc.iPipe1X = 17'sd107;
    waitCycles(6);
    checkOutput("x107_score", 32'(ifc.oScore), 32'h001);
    checkOutput("x107_pulses", 32'(pulseCount - pulseBase), 32'd1);
    checkOutput("x107_hit", 32'(ifc.oHit), 32'd0);
    ifc.iPipe1X = 17'sd640;
    waitCycles(4);
    sweepPipe1();
    waitCycles(5);
    checkOutput("x108b_score", 32'(ifc.oScore), 32'h001);
    ifc.iPipe1X = 17'sd107;
    waitCycles(6);
    checkOutput("sweep2_score", 32'(ifc.oScore), 32'h002);
    checkOutput("sweep2_pulses", 32'(pulseCount - pulseBase), 32'd2);
    checkOutput("sweep2_high", 32'(ifc.oHighScore), 32'h002);

    // Pipe 2 hits the bird above the gap
    collBase = collCount;
    pulseBase = pulseCount;
    setPipe(2, 150, 150);
    applyStimulus(2'd1, 100);
    waitCycles(6);
    checkOutput("pipehit_hit", 32'(ifc.oHit), 32'd1);
    checkOutput("pipehit_colls", 32'(collCount - collBase), 32'd1);
    setPipe(3, 100, 150);
    waitCycles(10);
    checkOutput("pipehit_sticky", 32'(ifc.oHit), 32'd1);
    checkOutput("pipehit_colls2", 32'(collCount - collBase), 32'd1);
    checkOutput("pipehit_noscore", 32'(ifc.oScore), 32'h002);
    checkOutput("pipehit_nopulse", 32'(pulseCount - pulseBase), 32'd0);
    applyStimulus(2'd2, 100);
    setPipe(1, 640, 150);
    setPipe(2, 640, 150);
    setPipe(3, 640, 150);
    waitCycles(2);
    checkOutput("over_hit", 32'(ifc.oHit), 32'd0);
    checkOutput("over_score", 32'(ifc.oScore), 32'h002);
    applyStimulus(2'd0, 100);
    waitCycles(2);
    checkOutput("idle0_score", 32'(ifc.oScore), 32'h000);
    checkOutput("idle0_high", 32'(ifc.oHighScore), 32'h002);
    applyStimulus(2'd1, 100);
    waitCycles(6);
    checkOutput("replay_hit", 32'(ifc.oHit), 32'd0);

    // Boundary hits with no valid pipes
    setPipe(1, 150, -1);
    setPipe(2, 640, -1);
    setPipe(3, 640, -1);
    applyStimulus(2'd1, 200);
    waitCycles(6);
    checkOutput("invalid_nohit", 32'(ifc.oHit), 32'd0);
    applyStimulus(2'd1, 460);
    waitCycles(3);
    checkOutput("floor_hit", 32'(ifc.oHit), 32'd1);
    applyStimulus(2'd2, 460);
    waitCycles(1);
    applyStimulus(2'd1, -1);
    waitCycles(3);
    checkOutput("ceiling_hit", 32'(ifc.oHit), 32'd1);
    applyStimulus(2'd2, -1);
    waitCycles(1);
    applyStimulus(2'd1, 456);
    waitCycles(6);
    checkOutput("floor_edge_nohit", 32'(ifc.oHit), 32'd0);

    // Reset while playing, then high score persistence across states
    setPipe(1, 640, 150);
    setPipe(2, 640, 150);
    setPipe(3, 640, 150);
    applyStimulus(2'd1, 170);
    reset = 1'b1;
    waitCycles(1);
    reset = 1'b0;
    checkOutput("rst2_high", 32'(ifc.oHighScore), 32'h000);
    repeat (5) doPass();
    checkOutput("hs_score5", 32'(ifc.oScore), 32'h005);
    checkOutput("hs_high5", 32'(ifc.oHighScore), 32'h005);
    applyStimulus(2'd2, 170);
    waitCycles(3);
    checkOutput("hs_held", 32'(ifc.oScore), 32'h005);
    applyStimulus(2'd0, 170);
    waitCycles(2);
    checkOutput("hs_cleared", 32'(ifc.oScore), 32'h000);
    checkOutput("hs_high_idle", 32'(ifc.oHighScore), 32'h005);
    applyStimulus(2'd1, 170);
    repeat (3) doPass();
    checkOutput("hs_score3", 32'(ifc.oScore), 32'h003);
    checkOutput("hs_high_kept", 32'(ifc.oHighScore), 32'h005);
    reset = 1'b1;
    waitCycles(1);
    reset = 1'b0;
    checkOutput("hs_reset_high", 32'(ifc.oHighScore), 32'h000);
    checkOutput("hs_reset_score", 32'(ifc.oScore), 32'h000);

    // BCD carry and saturation at 999
    repeat (9) doPass();
    checkOutput("bcd_009", 32'(ifc.oScore), 32'h009);
    doPass();
    checkOutput("bcd_010", 32'(ifc.oScore), 32'h010);
    repeat (988) doPass();
    checkOutput("bcd_998", 32'(ifc.oScore), 32'h998);
    pulseBase = pulseCount;
    doPass();
    checkOutput("bcd_999", 32'(ifc.oScore), 32'h999);
    doPass();
    checkOutput("bcd_sat", 32'(ifc.oScore), 32'h999);
    checkOutput("bcd_sat_pulses", 32'(pulseCount - pulseBase), 32'd2);
    checkOutput("bcd_high", 32'(ifc.oHighScore), 32'h999);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_collision_scorer.md
Name: pipe_collision_scorer

Overview:
Downstream consumer of the pipe position generator in the flappy-bird game datapath. Takes the three pipe X/gap-Y pairs, the bird's vertical position and the game state. Scans the pipes round-robin, one per cycle, to detect bird/pipe and bird/boundary collisions and to count pipes passed. Drives a 3-digit BCD score, a persistent high score, and event flags that the game state FSM and sound logic consume.

Parameters:
SCREEN_WIDTH, 640, x coordinate where pipes respawn; X >= this means freshly respawned.
SCREEN_HEIGHT, 480, playfield height in pixels.
PIPE_WIDTH, 52, pipe width in pixels.
PIPE_GAP_HEIGHT, 100, vertical gap height; the gap spans rows Y .. Y+PIPE_GAP_HEIGHT-1.
BIRD_X, 160, fixed left edge of the bird.
BIRD_SIZE, 24, bird width and height (square hitbox).

Ports:
iClock  in  1  system clock
iReset  in  1  synchronous, active-high reset
iState  in  2  game state: 0 idle, 1 playing, 2 game over
iPipe1X, iPipe2X, iPipe3X  in  17 signed  pipe left edge
iPipe1Y, iPipe2Y, iPipe3Y  in  17 signed  gap top row; -1 = pipe not yet valid
iBirdY  in  17 signed  bird top edge
oScore  out  12  BCD score, 3 digits, [11:8] hundreds
oHighScore  out  12  BCD high score
oScorePulse  out  1  one-cycle pulse per score increment
oCollision  out  1  one-cycle pulse when a hit is first detected
oHit  out  1  sticky hit flag

Behaviour:
- Reset (iReset=1, synchronous): oScore=0, oHighScore=0, oScorePulse=0, oCollision=0, oHit=0, passed flags=0, scanner state=SCAN1.
- Scanner FSM: SCAN1 -> SCAN2 -> SCAN3 -> SCAN1. Advances only while iState==1 and oHit==0. Otherwise it holds in SCAN1.
- While iState!=1: all passed flags=0, oHit=0, oCollision=0, oScorePulse=0.
- Score: cleared while iState==0. Held unchanged while iState==2.
- Per-cycle evaluation of the selected pipe n (only when iState==1, oHit==0), all arithmetic 17-bit signed:
  - Pipe invalid (Yn == -1): no score and no pipe-collision check. The boundary check still runs.
  - Respawn: Xn >= SCREEN_WIDTH -> clear passed[n].
  - Pass: Xn+PIPE_WIDTH < BIRD_X and passed[n]==0 -> set passed[n], score +1, oScorePulse=1 next cycle.
  - Pipe hit requires horizontal overlap, Xn < BIRD_X+BIRD_SIZE and Xn+PIPE_WIDTH > BIRD_X, AND vertical miss, iBirdY < Yn or iBirdY+BIRD_SIZE > Yn+PIPE_GAP_HEIGHT.
  - Boundary hit: iBirdY < 0 or iBirdY+BIRD_SIZE > SCREEN_HEIGHT. Checked every scan cycle.
  - Any hit -> oHit=1 and oCollision=1 for exactly one cycle, both registered on the next edge.
- Latency: every pipe is evaluated once per 3 cycles. oCollision/oScorePulse assert at most 4 cycles after the geometric condition becomes true.
- Simultaneous pass and hit in the same evaluation: the score increments AND the hit is flagged.
- After oHit=1: no further score, pulses or scanning until iState leaves 1.
- BCD increment: a digit at 9 rolls to 0 with carry into the next digit. Score saturates at 999; at saturation oScorePulse still pulses.
- High score: on the cycle after any score update, if oScore > oHighScore then oHighScore=oScore. Cleared only by iReset, never by iState.
- iReset while playing overrides everything and applies reset values on the next edge.

Test Plan:
1. Reset, iState=1, pipes at X=640, Y=150, iBirdY=200 -> no pulses, oScore=000, oHit=0 for 1000 cycles.
2. Pipe1 X stepped 640->107, Y=150, iBirdY=170 -> exactly one oScorePulse when X+52<160 (X=107), oScore=001. Pipe1 re-set to 640 then swept again -> oScore=002.
3. Pipe2 X=150, Y=150, iBirdY=100 -> oCollision one-cycle pulse within 4 cycles, oHit stays 1, later passes produce no score. iState->2 then ->1 -> oHit=0, oScore=0 on the iState=0 pass.
4. iBirdY=460 (460+24>480), no valid pipes (all Y=-1) -> oHit=1. iBirdY=-1 -> oHit=1. iBirdY=456 -> no hit.
5. Force 9 passes then 1 -> oScore 009->010 (BCD carry); preload 998, two passes -> 999, 999, with two oScorePulses.
6. Score 5, iState 1->2->0->1, score 3 -> oHighScore=005 throughout. iReset -> oHighScore=000.
